// File: rtl/eth_hdr_write_ctrl.sv
// Single-shot Ethernet header issuer: captures dest/src MAC and EtherType when the sink is ready, then holds them with hdr_valid.
// Optional macro ETH_HDR_REARM_EN lets a second hdr_ready in DONE return to IDLE for another capture.

module eth_hdr_addr_add (
  input  logic [31:0] base_i,
  input  logic [31:0] offset_i,
  output logic [31:0] sum_o
);
  assign sum_o = base_i + offset_i;
endmodule

module eth_hdr_reg_store #(
  parameter int W = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          wen_i,
  input  logic [31:0]   addr_i,
  input  logic [W-1:0]  wdata_i,
  output logic [W-1:0]  rdata_o
);
  logic [W-1:0] data_q;
  logic [W-1:0] data_d;

  // Single entry: only address 0 is backed by storage.
  always_comb begin
    data_d = data_q;
    if (wen_i && (addr_i == 32'd0)) data_d = wdata_i;
  end

  always_ff @(posedge clk) begin
    if (rst) data_q <= '0;
    else     data_q <= data_d;
  end

  assign rdata_o = data_q;
endmodule

module eth_hdr_write_ctrl #(
  parameter int MAC_W  = 48,
  parameter int TYPE_W = 16,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [MAC_W-1:0]  arg_0_out_data,
  input  logic [MAC_W-1:0]  arg_1_out_data,
  input  logic [TYPE_W-1:0] arg_2_out_data,
  input  logic              arg_3_busy,
  input  logic              arg_3_s_eth_hdr_ready,
  input  logic              arg_3_s_eth_payload_axis_tready,
  output logic              arg_3_s_eth_hdr_valid,
  output logic [MAC_W-1:0]  arg_3_s_eth_dest_mac,
  output logic [MAC_W-1:0]  arg_3_s_eth_src_mac,
  output logic [TYPE_W-1:0] arg_3_s_eth_type,
  output logic [DATA_W-1:0] arg_3_s_eth_payload_axis_tdata,
  output logic              arg_3_s_eth_payload_axis_tlast,
  output logic              arg_3_s_eth_payload_axis_tuser,
  output logic              arg_3_s_eth_payload_axis_tvalid,
  output logic              arg_3_m_axis_tready,
  output logic              valid
);

  typedef enum logic {
    IDLE = 1'b0,
    DONE = 1'b1
  } state_t;

  state_t      state_q;
  state_t      state_d;
  logic        cap_wen;
  logic        hdr_valid_d;
  logic [31:0] dest_addr;
  logic [31:0] src_addr;
  logic [31:0] type_addr;
  logic        unused_ok;

  // Busy and payload tready have no influence on a header-only issue.
  assign unused_ok = ^{arg_3_busy, arg_3_s_eth_payload_axis_tready};

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d     = state_q;
    cap_wen     = 1'b0;
    hdr_valid_d = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (arg_3_s_eth_hdr_ready) begin
          cap_wen = 1'b1;
          state_d = DONE;
        end
      end
      DONE: begin
        hdr_valid_d = 1'b1;
`ifdef ETH_HDR_REARM_EN
        if (arg_3_s_eth_hdr_ready) state_d = IDLE;
`endif
      end
      default: state_d = IDLE;
    endcase
  end

  eth_hdr_addr_add u_dest_addr (.base_i(32'd0), .offset_i(32'd0), .sum_o(dest_addr));
  eth_hdr_addr_add u_src_addr  (.base_i(32'd0), .offset_i(32'd0), .sum_o(src_addr));
  eth_hdr_addr_add u_type_addr (.base_i(32'd0), .offset_i(32'd0), .sum_o(type_addr));

  eth_hdr_reg_store #(.W(MAC_W)) u_dest_store (
    .clk    (clk),
    .rst    (rst),
    .wen_i  (cap_wen),
    .addr_i (dest_addr),
    .wdata_i(arg_0_out_data),
    .rdata_o(arg_3_s_eth_dest_mac)
  );

  eth_hdr_reg_store #(.W(MAC_W)) u_src_store (
    .clk    (clk),
    .rst    (rst),
    .wen_i  (cap_wen),
    .addr_i (src_addr),
    .wdata_i(arg_1_out_data),
    .rdata_o(arg_3_s_eth_src_mac)
  );

  eth_hdr_reg_store #(.W(TYPE_W)) u_type_store (
    .clk    (clk),
    .rst    (rst),
    .wen_i  (cap_wen),
    .addr_i (type_addr),
    .wdata_i(arg_2_out_data),
    .rdata_o(arg_3_s_eth_type)
  );

  assign arg_3_s_eth_hdr_valid           = hdr_valid_d;
  assign valid                           = hdr_valid_d;
  assign arg_3_s_eth_payload_axis_tdata  = '0;
  assign arg_3_s_eth_payload_axis_tlast  = 1'b0;
  assign arg_3_s_eth_payload_axis_tuser  = 1'b0;
  assign arg_3_s_eth_payload_axis_tvalid = 1'b0;
  assign arg_3_m_axis_tready             = 1'b0;

endmodule

// File: tb/tb_eth_hdr_write_ctrl.sv
// Scoreboard bench for eth_hdr_write_ctrl: directed scenarios followed by random ready/reset/argument traffic.
module tb_eth_hdr_write_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [47:0] a0 = '0;
  logic [47:0] a1 = '0;
  logic [15:0] a2 = '0;
  logic        busy = 1'b0;
  logic        hdr_ready = 1'b0;
  logic        pl_tready = 1'b0;

  logic        hdr_valid;
  logic [47:0] dest_mac;
  logic [47:0] src_mac;
  logic [15:0] eth_type;
  logic [7:0]  pl_tdata;
  logic        pl_tlast;
  logic        pl_tuser;
  logic        pl_tvalid;
  logic        m_tready;
  logic        fn_valid;

  always #5 clk = ~clk;

  eth_hdr_write_ctrl dut (
    .clk                            (clk),
    .rst                            (rst),
    .arg_0_out_data                 (a0),
    .arg_1_out_data                 (a1),
    .arg_2_out_data                 (a2),
    .arg_3_busy                     (busy),
    .arg_3_s_eth_hdr_ready          (hdr_ready),
    .arg_3_s_eth_payload_axis_tready(pl_tready),
    .arg_3_s_eth_hdr_valid          (hdr_valid),
    .arg_3_s_eth_dest_mac           (dest_mac),
    .arg_3_s_eth_src_mac            (src_mac),
    .arg_3_s_eth_type               (eth_type),
    .arg_3_s_eth_payload_axis_tdata (pl_tdata),
    .arg_3_s_eth_payload_axis_tlast (pl_tlast),
    .arg_3_s_eth_payload_axis_tuser (pl_tuser),
    .arg_3_s_eth_payload_axis_tvalid(pl_tvalid),
    .arg_3_m_axis_tready            (m_tready),
    .valid                          (fn_valid)
  );

  typedef struct packed {
    logic        hv;
    logic        v;
    logic [47:0] d;
    logic [47:0] s;
    logic [15:0] t;
  } exp_t;

  exp_t expq[$];
  int   n_checks = 0;
  int   n_pass   = 0;
  int   n_cycles = 0;

  // Reference: a header is "issued" once accepted and stays issued until reset (or re-armed).
  bit          m_issued = 1'b0;
  logic [47:0] m_dest = '0;
  logic [47:0] m_src  = '0;
  logic [15:0] m_type = '0;

  task automatic check(input string name, input logic [47:0] act, input logic [47:0] req);
    n_checks++;
    if (act === req) n_pass++;
    else $display("FAIL %s cycle %0d: got %h, expected %h", name, n_cycles, act, req);
  endtask

  task automatic step(input logic r, input logic rdy, input logic [47:0] d,
                      input logic [47:0] s, input logic [15:0] t);
    exp_t e;
    @(negedge clk);
    rst       = r;
    hdr_ready = rdy;
    a0        = d;
    a1        = s;
    a2        = t;
    busy      = 1'($urandom);
    pl_tready = 1'($urandom);
    if (r) begin
      m_issued = 1'b0;
      m_dest = '0; m_src = '0; m_type = '0;
    end else if (!m_issued) begin
      if (rdy) begin
        m_issued = 1'b1;
        m_dest = d; m_src = s; m_type = t;
      end
    end else begin
`ifdef ETH_HDR_REARM_EN
      if (rdy) m_issued = 1'b0;
`endif
    end
    e.hv = m_issued;
    e.v  = m_issued;
    e.d  = m_dest;
    e.s  = m_src;
    e.t  = m_type;
    expq.push_back(e);
  endtask

  // Monitor: every edge the DUT presents a full output set; compare it to the oldest expectation.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      n_cycles++;
      if (expq.size() > 0) begin
        e = expq.pop_front();
        check("hdr_valid", {47'd0, hdr_valid}, {47'd0, e.hv});
        check("valid",     {47'd0, fn_valid},  {47'd0, e.v});
        check("dest_mac",  dest_mac, e.d);
        check("src_mac",   src_mac,  e.s);
        check("eth_type",  {32'd0, eth_type}, {32'd0, e.t});
        check("payload_tieoff", {36'd0, pl_tdata, pl_tlast, pl_tuser, pl_tvalid, m_tready},
              48'd0);
      end
    end
  end

  initial begin
    int wait_cycles;
    // Reset for two cycles, then a five-cycle wait with ready low.
    step(1'b1, 1'b0, '0, '0, '0);
    step(1'b1, 1'b0, '0, '0, '0);
    for (int i = 0; i < 5; i++)
      step(1'b0, 1'b0, {$urandom, 16'h1234}, {$urandom, 16'h5678}, 16'(($urandom)));
    // Directed capture.
    step(1'b0, 1'b1, 48'h0102_0304_0506, 48'hAABB_CCDD_EEFF, 16'h0800);
    // Hold with all-ones arguments and ready low, then the mid-run reset and recapture.
    for (int i = 0; i < 4; i++)
      step(1'b0, 1'b0, '1, '1, '1);
    step(1'b1, 1'b0, '1, '1, '1);
    step(1'b0, 1'b0, 48'h1111_2222_3333, 48'h4444_5555_6666, 16'h86DD);
    step(1'b0, 1'b1, 48'h1111_2222_3333, 48'h4444_5555_6666, 16'h86DD);
    step(1'b0, 1'b1, 48'h7777_7777_7777, 48'h8888_8888_8888, 16'h0806);
    step(1'b0, 1'b0, '0, '0, '0);
    step(1'b0, 1'b1, 48'h9999_AAAA_BBBB, 48'hCCCC_DDDD_EEEE, 16'h88CC);
    step(1'b0, 1'b0, '0, '0, '0);
    // Random traffic: occasional reset, frequent ready toggling.
    for (int i = 0; i < 400; i++)
      step(($urandom_range(0, 19) == 0), 1'($urandom),
           {16'($urandom), 32'($urandom)}, {16'($urandom), 32'($urandom)}, 16'($urandom));
    // Drain the scoreboard within a bounded number of cycles.
    wait_cycles = 0;
    while (expq.size() > 0 && wait_cycles < 10) begin
      @(posedge clk);
      wait_cycles++;
    end
    @(negedge clk);
    n_checks++;
    if (expq.size() == 0) n_pass++;
    else $display("FAIL scoreboard_drain: %0d entries left, expected 0", expq.size());
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
